// File: rtl/rsa_modexp_ctrl.sv
// rsa_modexp_ctrl
// Sequencer for the small RSA encode/decode datapath. Computes
// result = base^exp mod modulus. The base is first brought below the
// modulus by repeated subtraction (one subtract per cycle). Then a
// fixed-latency LSB-first square-and-multiply runs over the exponent
// bits. Each modular product uses an interleaved shift-add multiplier
// that consumes one multiplier bit per cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, sampled only in IDLE or DONE
//   base     message / ciphertext
//   exp      exponent (e for encode, d for decode)
//   modulus  n
//   busy     high during REDUCE and EXP
//   sub_en   high during REDUCE (subtractor enable)
//   done     one-cycle pulse, result valid
//   err      modulus was zero; valid with done, held until next start
//   result   base^exp mod n, held until the next accepted start
module rsa_modexp_ctrl #(
    parameter int EXP_W = 4,
    parameter int DW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DW-1:0]    base,
    input  logic [EXP_W-1:0] exp,
    input  logic [DW-1:0]    modulus,
    output logic             busy,
    output logic             sub_en,
    output logic             done,
    output logic             err,
    output logic [DW-1:0]    result
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam int KW = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DW - 1);
    localparam logic [KW-1:0] K_MAX   = KW'(EXP_W - 1);

    typedef enum logic [1:0] {IDLE, REDUCE, EXP, DONE} state_t;

    state_t state, next_state;

    logic [DW-1:0]    b_reg;
    logic [EXP_W-1:0] e_reg;
    logic [DW-1:0]    n_reg;
    logic [DW-1:0]    acc_res;
    logic [DW-1:0]    acc_b;
    logic [DW-1:0]    t;
    logic [CW-1:0]    cnt;
    logic [KW-1:0]    k;
    logic             sqr_phase;

    logic             accept;
    logic             enter_exp;
    logic [DW-1:0]    enter_b;
    logic [DW-1:0]    enter_n;
    logic [DW-1:0]    b_minus;
    logic [DW-1:0]    mul_x;
    logic             y_bit;
    logic [DW:0]      n_ext;
    logic [DW:0]      dbl;
    logic [DW:0]      dbl_red;
    logic [DW:0]      add;
    logic [DW-1:0]    t_next;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic, handshake outputs and the one-cycle multiply step.
    // A start in DONE behaves exactly like a start in IDLE. A base that is
    // already below n skips REDUCE entirely.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        sub_en     = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;

        b_minus = b_reg - n_reg;

        case (state)
            IDLE: begin
                accept = start;
            end
            REDUCE: begin
                busy   = 1'b1;
                sub_en = 1'b1;
                if (b_minus < n_reg) begin
                    next_state = EXP;
                end
            end
            EXP: begin
                busy = 1'b1;
                if (sqr_phase && cnt == CNT_MAX && k == K_MAX) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                accept     = start;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (accept) begin
            if (modulus == '0) begin
                next_state = DONE;
            end else if (base < modulus) begin
                next_state = EXP;
            end else begin
                next_state = REDUCE;
            end
        end

        enter_exp = (accept && modulus != '0 && base < modulus) ||
                    (state == REDUCE && b_minus < n_reg);
        enter_b   = accept ? base : b_minus;
        enter_n   = accept ? modulus : n_reg;

        // Interleaved modular multiply, MSB of y first. The multiplier
        // operand y is acc_b in both sub-phases; only x changes.
        // Because x and t are both below n, one conditional subtract after
        // each add is enough.
        mul_x   = sqr_phase ? acc_b : acc_res;
        y_bit   = acc_b[CNT_MAX - cnt];
        n_ext   = {1'b0, n_reg};
        dbl     = {t, 1'b0};
        dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
        add     = y_bit ? dbl_red + {1'b0, mul_x} : dbl_red;
        t_next  = (add >= n_ext) ? DW'(add - n_ext) : DW'(add);
    end

    // Operand latches, reduction and square-and-multiply datapath. The MUL
    // sub-phase always runs, so latency does not depend on the exponent.
    // Its product is committed only when the current exponent bit is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg     <= '0;
            e_reg     <= '0;
            n_reg     <= '0;
            acc_res   <= '0;
            acc_b     <= '0;
            t         <= '0;
            cnt       <= '0;
            k         <= '0;
            sqr_phase <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
        end else begin
            if (accept) begin
                b_reg  <= base;
                e_reg  <= exp;
                n_reg  <= modulus;
                err    <= (modulus == '0);
                result <= '0;
            end else if (state == REDUCE) begin
                b_reg <= b_minus;
            end

            if (enter_exp) begin
                acc_b     <= enter_b;
                acc_res   <= (enter_n == DW'(1)) ? '0 : DW'(1);
                t         <= '0;
                cnt       <= '0;
                k         <= '0;
                sqr_phase <= 1'b0;
            end else if (state == EXP) begin
                if (cnt == CNT_MAX) begin
                    t   <= '0;
                    cnt <= '0;
                    if (!sqr_phase) begin
                        if (e_reg[k]) begin
                            acc_res <= t_next;
                        end
                        sqr_phase <= 1'b1;
                    end else begin
                        acc_b     <= t_next;
                        sqr_phase <= 1'b0;
                        k         <= k + 1'b1;
                        if (k == K_MAX) begin
                            result <= acc_res;
                        end
                    end
                end else begin
                    t   <= t_next;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb_rsa_modexp_ctrl
// Self-checking bench for rsa_modexp_ctrl. It runs directed operations
// and then random ones. Each run is compared against a plain arithmetic
// model: repeated multiplication mod n, floor(base/n) for the reduction
// length, and a fixed 32-cycle exponent phase.
//
// Ports of the DUT are driven on the falling edge and sampled on the
// falling edge, away from the active rising edge.
module tb_rsa_modexp_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] base;
    logic [3:0] exp;
    logic [3:0] modulus;
    logic       busy;
    logic       sub_en;
    logic       done;
    logic       err;
    logic [3:0] result;

    int check_cnt = 0;
    int pass_cnt  = 0;

    rsa_modexp_ctrl #(.EXP_W(4), .DW(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base    (base),
        .exp     (exp),
        .modulus (modulus),
        .busy    (busy),
        .sub_en  (sub_en),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: base^exp mod n by repeated multiplication.
    function automatic int model_pow(input int b, input int e, input int n);
        int r;
        if (n == 0) return 0;
        r = 1 % n;
        for (int i = 0; i < e; i++) r = (r * b) % n;
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    endtask

    // Issues one operation and watches it for a bounded number of cycles.
    // With mid_start set, a second start with random operands is pulsed
    // while the operation is in its exponent phase. That start must have
    // no effect.
    task automatic apply_stimulus(input string tag, input logic [3:0] b,
                                  input logic [3:0] e, input logic [3:0] m,
                                  input bit mid_start);
        int busy_cnt = 0;
        int sub_cnt  = 0;
        int done_cnt = 0;
        int done_idx = -1;
        int exp_r;
        int exp_lat;
        int exp_res;
        logic [3:0] res_at_done = 4'hx;
        logic       err_at_done = 1'bx;

        exp_res = model_pow(int'(b), int'(e), int'(m));
        exp_r   = (m == 0) ? 0 : int'(b) / int'(m);
        exp_lat = (m == 0) ? 0 : exp_r + 32;

        @(negedge clk);
        base = b; exp = e; modulus = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 70; c++) begin
            if (busy)   busy_cnt++;
            if (sub_en) sub_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = c;
                res_at_done = result;
                err_at_done = err;
            end
            if (mid_start && c == 12) begin
                start   = 1'b1;
                base    = 4'($urandom);
                exp     = 4'($urandom);
                modulus = 4'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end

        check_output({tag, " done_count"}, done_cnt, 1);
        check_output({tag, " done_latency"}, done_idx, exp_lat);
        check_output({tag, " busy_cycles"}, busy_cnt, exp_lat);
        check_output({tag, " sub_en_cycles"}, sub_cnt, exp_r);
        check_output({tag, " result"}, res_at_done, exp_res);
        check_output({tag, " err"}, err_at_done, (m == 0) ? 1 : 0);
        check_output({tag, " result_held"}, result, exp_res);
        check_output({tag, " err_held"}, err, (m == 0) ? 1 : 0);
    endtask

    initial begin
        $display("[TB] starting rsa_modexp_ctrl bench");
        rst_n = 1'b0; start = 1'b0; base = '0; exp = '0; modulus = '0;
        repeat (2) @(negedge clk);
        check_output("reset busy", busy, 0);
        check_output("reset sub_en", sub_en, 0);
        check_output("reset done", done, 0);
        check_output("reset err", err, 0);
        check_output("reset result", result, 0);
        rst_n = 1'b1;

        // Directed test plan.
        apply_stimulus("enc n15", 4'd7, 4'd3, 4'd15, 1'b0);
        apply_stimulus("dec n15", 4'd13, 4'd3, 4'd15, 1'b0);
        apply_stimulus("reduce2", 4'd14, 4'd2, 4'd5, 1'b0);
        apply_stimulus("exp15", 4'd2, 4'd15, 4'd11, 1'b0);
        apply_stimulus("exp0", 4'd3, 4'd0, 4'd7, 1'b0);
        apply_stimulus("mod0", 4'd9, 4'd5, 4'd0, 1'b0);
        apply_stimulus("after mod0", 4'd4, 4'd3, 4'd9, 1'b0);
        apply_stimulus("n1 midstart", 4'd9, 4'd5, 4'd1, 1'b1);
        apply_stimulus("base0", 4'd0, 4'd6, 4'd13, 1'b0);
        apply_stimulus("base eq n", 4'd11, 4'd4, 4'd11, 1'b0);
        apply_stimulus("b15 n1", 4'd15, 4'd0, 4'd1, 1'b0);

        // Reset in the middle of the exponent phase aborts immediately.
        @(negedge clk);
        base = 4'd7; exp = 4'd3; modulus = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("abort busy", busy, 0);
        check_output("abort sub_en", sub_en, 0);
        check_output("abort done", done, 0);
        check_output("abort result", result, 0);
        check_output("abort err", err, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_output("abort no done", done, 0);
        end
        rst_n = 1'b1;
        apply_stimulus("post abort", 4'd13, 4'd3, 4'd15, 1'b0);

        // Reset and start together: reset wins.
        @(negedge clk);
        rst_n = 1'b0; start = 1'b1; base = 4'd5; exp = 4'd2; modulus = 4'd7;
        @(negedge clk);
        check_output("rst+start busy", busy, 0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check_output("rst+start idle busy", busy, 0);
        check_output("rst+start idle done", done, 0);

        // Random operations.
        for (int i = 0; i < 24; i++) begin
            apply_stimulus("random", 4'($urandom), 4'($urandom),
                           4'($urandom_range(0, 15)), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_ctrl.md
Name: rsa_modexp_ctrl

Overview:
- Sequencer for the 4-bit RSA encode/decode datapath. Computes result = base^exp mod modulus on 4-bit operands.
- Pre-reduces the base with one borrow-subtract per cycle, then runs fixed-latency square-and-multiply over the 4 exponent bits.
- The same block serves encode (exp = e) and decode (exp = d). It owns the start/busy/done handshake seen by the top level.

Parameters:
- EXP_W, 4, exponent width; sets EXP phase length = EXP_W*8 cycles
- DW, 4, operand width; intermediates are DW+1 bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when idle
- base  in  4  message/ciphertext
- exp  in  4  exponent (e or d)
- modulus  in  4  n
- busy  out  1  high from cycle after accepted start through last compute cycle
- sub_en  out  1  high during REDUCE cycles (subtractor enable)
- done  out  1  one-cycle pulse, result valid
- err  out  1  modulus==0 flag, valid with done, held until next start
- result  out  4  base^exp mod n, held from done until next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, sub_en, done, err, result all 0; internal registers 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, REDUCE, EXP, DONE.
- IDLE/DONE + start=1 at edge:
  - Latch base, exp, modulus.
  - If modulus==0: go to DONE with err=1, result=0.
  - Else go to REDUCE.
  - A start in the DONE cycle is accepted exactly like one in IDLE.
- start in REDUCE/EXP is ignored; latched operands are unchanged.
- REDUCE:
  - Each cycle: b_reg <= b_reg - n; sub_en=1.
  - Leave to EXP when b_reg < n; check is made on entry too, so zero REDUCE cycles if base < n.
  - Cycle count r = floor(base/n).
- EXP entry:
  - acc_res = (n==1) ? 0 : 1.
  - acc_b = reduced base.
  - Bit index k = 0 (LSB first).
- Per exponent bit: MUL sub-phase of 4 cycles, then SQR sub-phase of 4 cycles.
  - MUL computes p = acc_res*acc_b mod n. Commit to acc_res only if exp[k]=1, so latency is fixed regardless of exp.
  - SQR computes acc_b <= acc_b*acc_b mod n every bit.
- Modular multiply x*y mod n, interleaved, MSB of y first, one y bit per cycle:
  - t <= 2*t, minus n if result >= n.
  - Then, if y[i]=1, t <= t + x, minus n if result >= n.
  - t starts at 0. Both adds done in one cycle on 5-bit values.
  - Invariant x, t < n guarantees a single conditional subtract suffices.
- After k=EXP_W-1 SQR completes: go to DONE; result <= acc_res.
  - EXP lasts exactly 32 cycles; busy cycles = r + 32.
- DONE (1 cycle): done=1, busy=0; then IDLE unless start accepted.
- Boundaries:
  - exp=0 gives result 1 (or 0 when n=1).
  - base=0 with exp>0 gives 0.
  - base==n reduces to 0 in 1 cycle.
  - base=15, n=1 takes 15 REDUCE cycles.
  - Simultaneous rst_n low and start: reset wins.

Test Plan:
- n=15, exp=3, base=7 -> r=0, busy 32 cycles, done pulse, result=13. Then base=13, exp=3 -> result=7 (encode/decode round trip).
- base=14, n=5, exp=2 -> sub_en high exactly 2 cycles, result=1, busy 34 cycles.
- base=2, n=11, exp=15 -> result=10. base=3, n=7, exp=0 -> result=1.
- modulus=0, base=9, exp=5 -> done in cycle after start, err=1, result=0, busy never high. Next valid start clears err.
- base=9, n=1, exp=5 -> r=9, result=0. Start pulsed mid-EXP is ignored (result unchanged, single done).
- rst_n dropped mid-EXP -> all outputs 0 immediately, no done. A new start after release completes normally with correct result.
